// File: rtl/usb_bus_monitor_pkg.sv
// usb_mon_pkg: shared line-state/event/FSM types and line decode helpers for the USB bus monitor.
package usb_mon_pkg;
  typedef enum logic [1:0] {LS_SE0 = 2'd0, LS_J = 2'd1, LS_K = 2'd2, LS_SE1 = 2'd3} line_state_e;
  typedef enum logic [2:0] {
    EV_SOP = 3'd0, EV_EOP = 3'd1, EV_RESET_START = 3'd2, EV_RESET_END = 3'd3, EV_ERROR = 3'd4
  } evt_code_e;
  typedef enum logic [1:0] {ST_IDLE, ST_PACKET, ST_EOP, ST_BUS_RESET} mon_state_e;
  function automatic line_state_e decode_ls(input logic dp, input logic dn, input logic low_speed);
    return (dp == dn) ? (dp ? LS_SE1 : LS_SE0) : ((dp ^ low_speed) ? LS_J : LS_K);
  endfunction
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction
endpackage

// File: rtl/usb_bus_monitor_if.sv
// usb_bus_monitor_if: event stream valid/ready port of the USB bus monitor.
interface usb_bus_monitor_if #(parameter int TS_WIDTH = 32);
  logic                evt_valid;
  logic                evt_ready;
  logic [2:0]          evt_code;
  logic [TS_WIDTH-1:0] evt_ts;
  logic [15:0]         evt_len;
  modport master (output evt_valid, evt_code, evt_ts, evt_len, input evt_ready);
  modport slave (input evt_valid, evt_code, evt_ts, evt_len, output evt_ready);
endinterface

// File: rtl/usb_bus_monitor_fifo.sv
// usb_mon_fifo: synchronous FIFO with registered head; accepts a push while full if a pop happens the same cycle.
module usb_mon_fifo #(
  parameter int  DEPTH = 16,
  parameter type T     = logic [7:0]
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid_i,
  input  T     in_data_i,
  output logic out_valid_o,
  input  logic out_ready_i,
  output T     out_data_o,
  output logic drop_o
);
  localparam int AW = $clog2(DEPTH);
  T mem_q [DEPTH];
  T head_q;
  logic [AW-1:0] wp_q, rp_q, rp_nx;
  logic [AW:0] cnt_q;
  logic full, empty, push, pop;
  assign empty       = cnt_q == '0;
  assign full        = cnt_q == (AW+1)'(DEPTH);
  assign pop         = !empty && out_ready_i;
  assign push        = in_valid_i && (!full || pop);
  assign drop_o      = in_valid_i && !push;
  assign rp_nx       = rp_q + AW'(1);
  assign out_valid_o = !empty;
  assign out_data_o  = head_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      if (push) wp_q <= wp_q + AW'(1);
      if (pop) rp_q <= rp_nx;
      cnt_q  <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      head_q <= (push && (empty || (pop && cnt_q == (AW+1)'(1)))) ? in_data_i :
                pop ? mem_q[rp_nx] : head_q;
    end
  end
  always_ff @(posedge clk) if (push) mem_q[wp_q] <= in_data_i;
endmodule

// File: rtl/usb_bus_monitor.sv
// usb_bus_monitor: passive USB FS/LS line monitor; decodes line state, tracks framing and bus reset,
// and queues timestamped events behind a valid/ready port.
module usb_bus_monitor
  import usb_mon_pkg::*;
#(
  parameter int OVERSAMPLE = 4,
  parameter int LOW_SPEED  = 0,
  parameter int RESET_BITS = 10,
  parameter int FIFO_DEPTH = 16,
  parameter int TS_WIDTH   = 32
) (
  input  logic                     clk48_host,
  input  logic                     reset,
  input  logic                     usb_d_p,
  input  logic                     usb_d_n,
  input  logic                     enable,
  output logic [1:0]               line_state,
  output logic                     bus_reset_active,
  output logic                     overflow,
  usb_bus_monitor_if.master        evt
);
  localparam logic        LS_POL  = LOW_SPEED != 0;
  localparam logic [1:0]  J_LVL   = LS_POL ? 2'b01 : 2'b10;
  localparam logic [15:0] RST_CYC = 16'(RESET_BITS * OVERSAMPLE);
  localparam logic [15:0] EOP_MIN = 16'(OVERSAMPLE);
  localparam logic [15:0] EOP_MAX = 16'(3 * OVERSAMPLE);
  typedef struct packed {
    evt_code_e           code;
    logic [TS_WIDTH-1:0] ts;
    logic [15:0]         len;
  } evt_t;
  logic [1:0] s1_q, s2_q;
  line_state_e ls, ls_prev_q;
  mon_state_e st_q, st_d;
  logic [15:0] run_q, pkt_q, pkt_d, len;
  logic [TS_WIDTH-1:0] ts_q;
  logic chg, long_se0, fire, drop, ovf_q;
  evt_code_e code;
  evt_t ev, head;
  assign ls               = decode_ls(s2_q[1], s2_q[0], LS_POL);
  assign line_state       = ls;
  assign chg              = ls != ls_prev_q;
  assign long_se0         = ls == LS_SE0 && !chg && run_q >= RST_CYC;
  assign bus_reset_active = st_q == ST_BUS_RESET;
  assign overflow         = ovf_q;
  assign ev               = {code, ts_q, len};
  assign evt.evt_code     = head.code;
  assign evt.evt_ts       = head.ts;
  assign evt.evt_len      = head.len;
  // run_q clears one cycle after a change, so on the change cycle it still holds the ended run's length
  always_ff @(posedge clk48_host) begin
    if (reset) begin
      s1_q      <= J_LVL;
      s2_q      <= J_LVL;
      ls_prev_q <= LS_J;
      run_q     <= '0;
      pkt_q     <= '0;
      ts_q      <= '0;
      st_q      <= ST_IDLE;
      ovf_q     <= 1'b0;
    end else begin
      s1_q      <= {usb_d_p, usb_d_n};
      s2_q      <= s1_q;
      ls_prev_q <= ls;
      run_q     <= chg ? 16'd1 : sat_inc(run_q);
      pkt_q     <= pkt_d;
      ts_q      <= ts_q + TS_WIDTH'(1);
      st_q      <= st_d;
      ovf_q     <= ovf_q | drop;
    end
  end
  always_comb begin
    st_d  = st_q;
    pkt_d = pkt_q;
    fire  = 1'b0;
    code  = EV_ERROR;
    len   = '0;
    case (st_q)
      ST_IDLE: begin
        if (ls == LS_K) begin
          st_d  = ST_PACKET;
          fire  = 1'b1;
          code  = EV_SOP;
          pkt_d = 16'd1;
        end else if (long_se0) begin
          st_d = ST_BUS_RESET;
          fire = 1'b1;
          code = EV_RESET_START;
          len  = run_q;
        end else if (ls == LS_SE1 && chg) fire = 1'b1;
      end
      ST_PACKET: begin
        if (ls == LS_SE0) st_d = ST_EOP;
        else if (ls == LS_SE1) begin
          st_d = ST_IDLE;
          fire = 1'b1;
          len  = pkt_q;
        end else pkt_d = sat_inc(pkt_q);
      end
      ST_EOP: begin
        if (ls == LS_J) begin
          st_d = ST_IDLE;
          fire = 1'b1;
          code = (run_q >= EOP_MIN && run_q <= EOP_MAX) ? EV_EOP : EV_ERROR;
          len  = pkt_q;
        end else if (ls != LS_SE0) begin
          st_d = ST_IDLE;
          fire = 1'b1;
        end else if (long_se0) begin
          st_d = ST_BUS_RESET;
          fire = 1'b1;
          code = EV_RESET_START;
          len  = run_q;
        end
      end
      ST_BUS_RESET: begin
        if (ls != LS_SE0) begin
          st_d = ST_IDLE;
          fire = 1'b1;
          code = EV_RESET_END;
          len  = run_q;
        end
      end
      default: st_d = ST_IDLE;
    endcase
    if (!enable) begin
      st_d = ST_IDLE;
      fire = 1'b0;
    end
  end
  usb_mon_fifo #(.DEPTH(FIFO_DEPTH), .T(evt_t)) u_fifo (
    .clk         (clk48_host),
    .rst         (reset),
    .in_valid_i  (fire),
    .in_data_i   (ev),
    .out_valid_o (evt.evt_valid),
    .out_ready_i (evt.evt_ready),
    .out_data_o  (head),
    .drop_o      (drop)
  );
endmodule

// File: tb/tb_usb_bus_monitor.sv
// tb_usb_bus_monitor: scoreboard bench for a full-speed and a low-speed monitor instance.
module tb_usb_bus_monitor;
  import usb_mon_pkg::*;
  localparam logic [1:0] FJ = 2'b10, FK = 2'b01, LJ = 2'b01, LK = 2'b10, SE0 = 2'b00, SE1 = 2'b11;
  typedef struct {
    logic [2:0]  code;
    logic [15:0] len;
    bit          chk_len;
    int          dts;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic dp0 = 1'b1, dn0 = 1'b0, dp1 = 1'b0, dn1 = 1'b1, en0 = 1'b1, en1 = 1'b1;
  logic [1:0] ls0, ls1;
  logic bra0, bra1, ovf0, ovf1;
  exp_t q0[$], q1[$];
  int ncmp = 0, nfail = 0, bra_cnt = 0;
  logic [31:0] last0 = '0, last1 = '0;
  always #5 clk = ~clk;
  usb_bus_monitor_if #(.TS_WIDTH(32)) e0 ();
  usb_bus_monitor_if #(.TS_WIDTH(32)) e1 ();
  usb_bus_monitor #(.OVERSAMPLE(4), .LOW_SPEED(0), .RESET_BITS(10), .FIFO_DEPTH(16), .TS_WIDTH(32)) dut0 (
    .clk48_host(clk), .reset(rst), .usb_d_p(dp0), .usb_d_n(dn0), .enable(en0), .line_state(ls0),
    .bus_reset_active(bra0), .overflow(ovf0), .evt(e0.master));
  usb_bus_monitor #(.OVERSAMPLE(32), .LOW_SPEED(1), .RESET_BITS(10), .FIFO_DEPTH(16), .TS_WIDTH(32)) dut1 (
    .clk48_host(clk), .reset(rst), .usb_d_p(dp1), .usb_d_n(dn1), .enable(en1), .line_state(ls1),
    .bus_reset_active(bra1), .overflow(ovf1), .evt(e1.master));

  task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] want);
    ncmp++;
    if (got !== want) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  task automatic check(input int idx, input logic [2:0] c, input logic [31:0] ts, input logic [15:0] l);
    exp_t x;
    logic [31:0] dt;
    int n;
    n = (idx == 0) ? q0.size() : q1.size();
    dt = ts - ((idx == 0) ? last0 : last1);
    ncmp++;
    if (n == 0) begin
      nfail++;
      $display("FAIL evt%0d unexpected: got code=%0d len=%0d, want no event", idx, c, l);
    end else begin
      if (idx == 0) x = q0.pop_front();
      else x = q1.pop_front();
      if (c !== x.code || (x.chk_len && l !== x.len) || (x.dts >= 0 && dt !== 32'(x.dts))) begin
        nfail++;
        $display("FAIL evt%0d: got code=%0d len=%0d dts=%0d, want code=%0d len=%0d dts=%0d",
                 idx, c, l, dt, x.code, x.len, x.dts);
      end
    end
    if (idx == 0) last0 = ts;
    else last1 = ts;
  endtask

  always @(negedge clk) begin
    if (e0.evt_valid && e0.evt_ready) check(0, e0.evt_code, e0.evt_ts, e0.evt_len);
    if (e1.evt_valid && e1.evt_ready) check(1, e1.evt_code, e1.evt_ts, e1.evt_len);
    if (bra0) bra_cnt++;
  end

  task automatic expect_evt(input int idx, input logic [2:0] c, input logic [15:0] l, input bit cl, input int d);
    exp_t x;
    x = '{code: c, len: l, chk_len: cl, dts: d};
    if (idx == 1) q1.push_back(x);
    else if (q0.size() < 16) q0.push_back(x);
  endtask

  task automatic l0(input logic [1:0] v, input int n);
    {dp0, dn0} = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic l1(input logic [1:0] v, input int n);
    {dp1, dn1} = v;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pkt0(input int k, input int se0, input bit good);
    expect_evt(0, EV_SOP, 16'd0, 1'b1, -1);
    l0(FK, k);
    l0(SE0, se0);
    if (good) expect_evt(0, EV_EOP, 16'(k), 1'b1, k + se0);
    else expect_evt(0, EV_ERROR, 16'd0, 1'b0, -1);
    l0(FJ, 6);
  endtask

  task automatic drain(input int idx, input string name);
    int n;
    n = 0;
    repeat (8) begin @(posedge clk); #1; end
    while (((idx == 0) ? q0.size() : q1.size()) != 0 && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    cmp(name, (idx == 0) ? q0.size() : q1.size(), 0);
  endtask

  initial begin
    e0.evt_ready = 1'b1;
    e1.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    cmp("rst_line_state0", 32'(ls0), 1);
    cmp("rst_line_state1", 32'(ls1), 1);
    cmp("rst_bus_reset", {30'd0, bra0, bra1}, 0);
    cmp("rst_evt_valid", {30'd0, e0.evt_valid, e1.evt_valid}, 0);
    cmp("rst_evt_code", 32'(e0.evt_code), 0);
    cmp("rst_evt_ts", e0.evt_ts, 0);
    cmp("rst_evt_len", 32'(e0.evt_len), 0);
    cmp("rst_overflow", {30'd0, ovf0, ovf1}, 0);
    rst = 1'b0;
    l0(FJ, 10);
    pkt0(32, 8, 1'b1);
    drain(0, "fs_packet_drain");
    bra_cnt = 0;
    expect_evt(0, EV_RESET_START, 16'd40, 1'b1, -1);
    l0(SE0, 100);
    expect_evt(0, EV_RESET_END, 16'd100, 1'b1, 60);
    l0(FJ, 10);
    drain(0, "bus_reset_drain");
    cmp("bus_reset_active_cycles", bra_cnt, 60);
    pkt0(12, 4, 1'b1);
    pkt0(12, 12, 1'b1);
    pkt0(16, 2, 1'b0);
    pkt0(16, 13, 1'b0);
    drain(0, "eop_bounds_drain");
    expect_evt(0, EV_SOP, 16'd0, 1'b1, -1);
    l0(FK, 10);
    expect_evt(0, EV_ERROR, 16'd10, 1'b1, 10);
    l0(SE1, 5);
    l0(FJ, 8);
    pkt0(20, 8, 1'b1);
    drain(0, "se1_drain");
    en0 = 1'b0;
    l0(FK, 10);
    l0(SE0, 8);
    l0(FJ, 6);
    en0 = 1'b1;
    drain(0, "disabled_drain");
    l1(LJ, 50);
    expect_evt(1, EV_SOP, 16'd0, 1'b1, -1);
    l1(LK, 256);
    l1(SE0, 64);
    expect_evt(1, EV_EOP, 16'd256, 1'b1, 320);
    l1(LJ, 20);
    drain(1, "low_speed_drain");
    e0.evt_ready = 1'b0;
    for (int i = 0; i < 18; i++) pkt0(8 + i, 6, 1'b1);
    cmp("overflow_set", 32'(ovf0), 1);
    cmp("full_valid", 32'(e0.evt_valid), 1);
    e0.evt_ready = 1'b1;
    drain(0, "overflow_drain");
    cmp("overflow_sticky", 32'(ovf0), 1);
    e0.evt_ready = 1'b0;
    pkt0(8, 6, 1'b1);
    expect_evt(0, EV_SOP, 16'd0, 1'b1, -1);
    l0(FK, 10);
    cmp("three_held_valid", 32'(e0.evt_valid), 1);
    rst = 1'b1;
    q0.delete();
    l0(SE0, 1);
    cmp("flush_valid", 32'(e0.evt_valid), 0);
    l0(SE0, 3);
    rst = 1'b0;
    l0(SE0, 3);
    e0.evt_ready = 1'b1;
    l0(FJ, 20);
    drain(0, "post_reset_drain");
    cmp("overflow_cleared", {30'd0, ovf0, ovf1}, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
